key_encoder: RTL
================

KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable cycles needed before a code is presented; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 d  input  4  one-hot request lines d[0]..d[3], asynchronous to nothing (same clk domain), sampled each cycle.
REQ-005 a  output  1  encoded code MSB (d3,d2 -> 1).
REQ-006 b  output  1  encoded code LSB (d3,d1 -> 1).
REQ-007 valid  output  1  code on {a,b} is stable and owned by the consumer until ack.
REQ-008 ack  input  1  consumer accepts the code; meaningful only while valid=1.
REQ-009 err  output  1  one-cycle pulse on multi-hot input (feature-dependent, see Configuration).

Function
REQ-010 Encoding SHALL be d[0]->{a,b}=00, d[1]->01, d[2]->10, d[3]->11.
REQ-011 Input d SHALL be registered once into d_q; all decisions use d_q.
REQ-012 FSM states SHALL be IDLE, SETTLE, PRESENT, RELEASE.
REQ-013 IDLE: d_q!=0 -> SETTLE, cand<=d_q, cnt<=0; d_q==0 -> stay.
REQ-014 SETTLE: d_q==0 -> IDLE; d_q!=cand -> stay in SETTLE, cand<=d_q, cnt<=0 (restart); d_q==cand and cnt==DEBOUNCE_CYCLES-1 -> PRESENT; else cnt<=cnt+1.
REQ-015 On SETTLE->PRESENT, {a,b} SHALL load the encoding of cand and valid SHALL rise on the same edge.
REQ-016 Latency: d stable from before edge E0 -> valid high after edge E(DEBOUNCE_CYCLES+1) (6th edge for default).
REQ-017 PRESENT: valid=1, {a,b} held constant regardless of d; valid&ack sampled high -> RELEASE, valid low after that edge.
REQ-018 ack while valid=0 SHALL be ignored; ack may be held high permanently (handshake completes on first cycle valid is seen, one PRESENT cycle).
REQ-019 RELEASE: d_q==0 -> IDLE; otherwise stay (no repeat code for a held line).
REQ-020 {a,b} SHALL retain last presented code outside PRESENT.
REQ-021 cnt SHALL be 8 bits and never wrap (bounded by REQ-014).

Reset
REQ-022 rst=1 at any edge SHALL force state=IDLE, d_q=0, cand=0, cnt=0, a=0, b=0, valid=0, err=0, overriding all other activity, including mid-SETTLE or mid-PRESENT (pending code discarded).
REQ-023 After rst deasserts with a line already held, normal detection SHALL start from IDLE (code is presented once).

Configuration
REQ-024 Macro KEY_ENCODER_MULTI_ERR_EN defined: d_q with more than one bit set in IDLE or SETTLE SHALL pulse err=1 for one cycle, move to RELEASE, and never assert valid for it.
REQ-025 Macro undefined: multi-hot input SHALL be priority-encoded (highest set index wins) and treated as that single line; err SHALL be tied 0.

Structure
REQ-026 Shared package key_encoder_pkg SHALL hold the state enum typedef and the four 2-bit code constants.
REQ-027 Sub-module onehot_prio_enc (combinational 4->2 priority encode plus multi-hot flag) SHALL be instantiated once on cand/d_q.

Verification
REQ-028 d=0100 held, ack=0 -> valid=1, {a,b}=10 after 6th edge; stays until ack=1 for one cycle, then valid=0 next edge.
REQ-029 d=0010 for 3 cycles then 0 (bounce) -> valid never asserts, FSM back in IDLE.
REQ-030 d=1000 held through ack and 10 further cycles -> exactly one valid pulse, {a,b}=11; release to 0000, then d=0001 -> new code 00.
REQ-031 d=1010: with macro -> err=1 one cycle, no valid; without -> valid with {a,b}=11, err=0.
REQ-032 rst=1 asserted while valid=1 -> next edge valid=0, a=b=0, state IDLE; held d=0010 after rst release -> code 01 presented once.
REQ-033 ack=1 tied high, d=0001 -> valid high exactly one cycle, {a,b}=00.

Source files
------------

// File: rtl/key_encoder_pkg.sv
// Shared types and code constants for the debounced 4-line key encoder.
package key_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] CODE_D0 = 2'b00;
    localparam logic [1:0] CODE_D1 = 2'b01;
    localparam logic [1:0] CODE_D2 = 2'b10;
    localparam logic [1:0] CODE_D3 = 2'b11;

    function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
        return 4'b0001 << code;
    endfunction

endpackage

// File: rtl/key_encoder_onehot_prio_enc.sv
// Combinational 4->2 priority encoder (highest index wins) with a multi-hot flag.
module onehot_prio_enc
    import key_encoder_pkg::*;
(
    input  logic [3:0] d,
    output logic [1:0] code,
    output logic       multi
);

    always_comb begin
        code = CODE_D0;
        if (d[3])      code = CODE_D3;
        else if (d[2]) code = CODE_D2;
        else if (d[1]) code = CODE_D1;
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = (d & (d - 4'd1)) != 4'd0;

endmodule

// File: rtl/key_encoder.sv
// Debounced one-hot key encoder with valid/ack handshake.
// Optional macro KEY_ENCODER_MULTI_ERR_EN: multi-hot input raises err instead of priority encoding.
module key_encoder
    import key_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    input  logic       ack,
    output logic       a,
    output logic       b,
    output logic       valid,
    output logic       err
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t     state;
    logic [3:0] d_q;
    logic [3:0] cand;
    logic [7:0] cnt;
    logic [1:0] code;
    logic       multi;
    logic [3:0] d_sel;
    logic       multi_err;

    onehot_prio_enc u_enc (
        .d     (d_q),
        .code  (code),
        .multi (multi)
    );

`ifdef KEY_ENCODER_MULTI_ERR_EN
    assign d_sel     = d_q;
    assign multi_err = multi;
`else
    // Multi-hot input collapses to the single highest line.
    logic unused_multi;
    assign unused_multi = multi;
    assign d_sel        = (d_q == 4'd0) ? 4'd0 : code_to_onehot(code);
    assign multi_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            d_q   <= 4'd0;
            cand  <= 4'd0;
            cnt   <= 8'd0;
            a     <= 1'b0;
            b     <= 1'b0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            d_q <= d;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (multi_err) begin
                        err   <= 1'b1;
                        state <= RELEASE;
                    end else if (d_sel != 4'd0) begin
                        state <= SETTLE;
                        cand  <= d_sel;
                        cnt   <= 8'd0;
                    end
                end
                SETTLE: begin
                    if (d_q == 4'd0) begin
                        state <= IDLE;
                    end else if (multi_err) begin
                        err   <= 1'b1;
                        state <= RELEASE;
                    end else if (d_sel != cand) begin
                        cand <= d_sel;
                        cnt  <= 8'd0;
                    end else if (cnt == CNT_LAST) begin
                        // d_sel equals cand here, so the encoder output is cand's code.
                        state    <= PRESENT;
                        {a, b}   <= code;
                        valid    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (d_q == 4'd0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
